store_commit_buffer: RTL and testbench
======================================

# store_commit_buffer

Holds committed stores between the reorder buffer and the byte-addressed data memory, and drains them to the memory's write port in program order. Each store is accepted at ROB commit and drained at most one per cycle through a registered write port. Speculative loads from the load/store unit can look up the buffer, so they can either take forwarded data or be told to wait. The block sits between ROB commit and the data memory write inputs (write enable, address, funct3, write data).

## Interface
- DEPTH, 4, number of buffer entries; power of two, ≥ 2
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- st_valid  in  1  ROB presents a committed store
- st_ready  out  1  buffer can accept; equals !full, no same-cycle pop bypass
- st_addr  in  32  store byte address
- st_funct3  in  3  000 SB, 001 SH, 010 SW; other codes are consumed by the handshake but not enqueued
- st_data  in  32  store data, low bytes used
- drain_en  in  1  memory write port available this cycle
- mem_we  out  1  registered write strobe to data memory
- mem_addr  out  32  registered write address
- mem_funct3  out  3  registered store width
- mem_wdata  out  32  registered write data
- ld_valid  in  1  load lookup request
- ld_addr  in  32  load byte address
- ld_funct3  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- ld_fwd_hit  out  1  combinational; forwarded data valid
- ld_fwd_data  out  32  combinational; extended forwarded value, 0 when no hit
- ld_conflict  out  1  combinational; load must stall and retry
- count  out  $clog2(DEPTH)+1  occupied entries
- empty  out  1  count == 0 and mem_we == 0

## Operation
- The buffer is a circular FIFO with head/tail pointers of $clog2(DEPTH) bits that wrap modulo DEPTH, plus a separate count register.
- **Enqueue:** on st_valid && st_ready with a valid funct3, write {addr, funct3, data} at tail, then advance tail.
- **Drain:** when count > 0 and drain_en, load the head entry into the mem_* registers, set mem_we = 1, and pop head. Otherwise mem_we = 0; mem_addr, mem_funct3 and mem_wdata hold their values.
- **Simultaneous enqueue and pop:** count is unchanged. At full, st_ready stays 0 even if a pop occurs in the same cycle.
- **Store byte ranges:** a store covers [addr, addr+size−1], with size 1/2/4 from its funct3.
- **Load byte ranges:** a load covers size 1 for 000/100, 2 for 001/101, 4 for 010. For any other ld_funct3 the lookup outputs are all 0.
- **Range arithmetic:** computed in 33 bits, with no wrap across 0xFFFFFFFF. Misaligned accesses are legal.
- **Lookup scope:** all valid buffer entries plus the in-flight mem_* stage when mem_we = 1. The in-flight stage is the oldest. Outputs are active only when ld_valid = 1.
- **Lookup priority:** the youngest store whose range overlaps the load decides the result. Stores accepted in the current cycle are not visible.
- **Hit vs conflict:** if the youngest overlapping store covers every load byte, ld_fwd_hit = 1. Otherwise ld_conflict = 1. No overlap gives both 0.
- **Forwarded data:** the load bytes are taken from that store's data at byte offset (ld_addr − st_addr). Signed loads (LB, LH) sign-extend from the top loaded byte's bit 7; unsigned loads (LBU, LHU) zero-extend.
- Committed stores are never flushed; only reset discards them.

## Timing
- **Reset values:** head = 0, tail = 0, count = 0, empty = 1, st_ready = 1; mem_we = 0, mem_addr = 0, mem_funct3 = 0, mem_wdata = 0.
- **Reset mid-operation:** all entries are discarded, and mem_we is 0 in the following cycle.
- **Minimum latency:** a store accepted at the edge ending cycle N is the head in cycle N+1. If drain_en = 1 in N+1, mem_we is high for exactly one cycle, N+2.
- **Throughput:** one drain per cycle while drain_en stays high.
- **Lookup:** zero-cycle combinational path from ld_* and buffer state.
- **Visibility window:** the in-flight stage is included in lookups because the memory commits the write at the edge ending the mem_we cycle.

## Configuration
- STBUF_FWD_EN defined: forwarding behaves as described in Operation.
- STBUF_FWD_EN undefined:
  - any overlap sets ld_conflict = 1;
  - ld_fwd_hit and ld_fwd_data are tied to 0;
  - the extraction and extension logic is not built.

## Test plan
- **Single store drain:** reset, then SW 0x100 / 0xDEADBEEF accepted with drain_en = 1 → mem_we = 1 only in the second cycle after acceptance, with mem_addr 0x100, mem_funct3 010, mem_wdata 0xDEADBEEF; empty = 1 the cycle after.
- **Fill and drain order:** drain_en = 0, four stores to 0x0/0x4/0x8/0xC → count = 4, st_ready = 0, fifth store held. Then drain_en = 1 → four consecutive mem_we pulses in order 0x0, 0x4, 0x8, 0xC, then the fifth store.
- **Forwarding extraction:** SW 0x200 / 0x80818283 buffered →
  - LB 0x201: hit, 0xFFFFFF82;
  - LBU 0x203: hit, 0x00000080;
  - LW 0x200: hit, 0x80818283;
  - LW 0x204: no hit, no conflict.
- **Youngest wins:** SW 0x300 / 0x11111111, then SB 0x300 / 0xAA → LW 0x300: conflict = 1; LB 0x300: hit, 0xFFFFFFAA; LBU 0x301: hit, 0x00000011.
- **In-flight stage:** SH 0x40 / 0x1234 with LHU 0x40 looked up during its mem_we cycle → hit, 0x00001234.
- **Reset mid-drain and non-forwarding build:**
  - reset with 3 entries buffered → next cycle mem_we = 0, count = 0, no further writes;
  - without STBUF_FWD_EN, the forwarding-extraction scenario gives conflict = 1, hit = 0 for the three overlapping loads.

Source files
------------

// File: rtl/store_commit_buffer.sv
// -----------------------------------------------------------------------------
// store_commit_buffer
//
// Holds committed stores between ROB commit and the data memory write port.
// Stores drain in program order, at most one per cycle, through a registered
// write stage (mem_*). Speculative loads can look up the buffer without
// waiting a cycle. A load either takes forwarded data or is told to stall and
// retry.
//
// Optional feature macro: STBUF_FWD_EN
//   defined   : a load fully covered by the youngest overlapping store gets
//               forwarded, extended data (ld_fwd_hit / ld_fwd_data).
//   undefined : any overlap raises ld_conflict. ld_fwd_hit and ld_fwd_data
//               are tied to 0, and no extraction logic is built.
//
// Ports
//   clk, reset            clock; synchronous active-high reset
//   st_valid/st_ready     ROB store handshake; st_ready = !full
//   st_addr/funct3/data   committed store (funct3 000 SB, 001 SH, 010 SW)
//   drain_en              memory write port available this cycle
//   mem_we/addr/funct3/wdata  registered write stage toward data memory
//   ld_valid/addr/funct3  load lookup request (combinational)
//   ld_fwd_hit/data       forwarded load value
//   ld_conflict           load must stall and retry
//   count, empty          occupancy; empty also requires mem_we == 0
// -----------------------------------------------------------------------------
module store_commit_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   st_valid,
  output logic                   st_ready,
  input  logic [31:0]            st_addr,
  input  logic [2:0]             st_funct3,
  input  logic [31:0]            st_data,
  input  logic                   drain_en,
  output logic                   mem_we,
  output logic [31:0]            mem_addr,
  output logic [2:0]             mem_funct3,
  output logic [31:0]            mem_wdata,
  input  logic                   ld_valid,
  input  logic [31:0]            ld_addr,
  input  logic [2:0]             ld_funct3,
  output logic                   ld_fwd_hit,
  output logic [31:0]            ld_fwd_data,
  output logic                   ld_conflict,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(32'd1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);

  // Store width in bytes; 0 marks a code that is not a store.
  function automatic logic [2:0] st_size_f(input logic [2:0] f3);
    case (f3)
      3'b000:  st_size_f = 3'd1;
      3'b001:  st_size_f = 3'd2;
      3'b010:  st_size_f = 3'd4;
      default: st_size_f = 3'd0;
    endcase
  endfunction

  // Load width in bytes; 0 marks an unsupported load code.
  function automatic logic [2:0] ld_size_f(input logic [2:0] f3);
    case (f3)
      3'b000:  ld_size_f = 3'd1;
      3'b100:  ld_size_f = 3'd1;
      3'b001:  ld_size_f = 3'd2;
      3'b101:  ld_size_f = 3'd2;
      3'b010:  ld_size_f = 3'd4;
      default: ld_size_f = 3'd0;
    endcase
  endfunction

  // Byte-range overlap. The ranges use 33 bits so that an access near
  // 0xFFFFFFFF never wraps around to address 0.
  function automatic logic overlap_f(input logic [31:0] s_addr, input logic [2:0] s_size,
                                     input logic [31:0] l_addr, input logic [2:0] l_size);
    logic [32:0] s_lo;
    logic [32:0] s_hi;
    logic [32:0] l_lo;
    logic [32:0] l_hi;
    s_lo = {1'b0, s_addr};
    s_hi = s_lo + {30'd0, s_size} - 33'd1;
    l_lo = {1'b0, l_addr};
    l_hi = l_lo + {30'd0, l_size} - 33'd1;
    overlap_f = (s_lo <= l_hi) && (l_lo <= s_hi);
  endfunction

`ifdef STBUF_FWD_EN
  // True when the store range contains every byte of the load range.
  function automatic logic covers_f(input logic [31:0] s_addr, input logic [2:0] s_size,
                                    input logic [31:0] l_addr, input logic [2:0] l_size);
    logic [32:0] s_lo;
    logic [32:0] s_hi;
    logic [32:0] l_lo;
    logic [32:0] l_hi;
    s_lo = {1'b0, s_addr};
    s_hi = s_lo + {30'd0, s_size} - 33'd1;
    l_lo = {1'b0, l_addr};
    l_hi = l_lo + {30'd0, l_size} - 33'd1;
    covers_f = (s_lo <= l_lo) && (l_hi <= s_hi);
  endfunction
`endif

  // Entry payload storage. Only slots head..head+count-1 are meaningful.
  logic [31:0]   addr_q_r [DEPTH];
  logic [2:0]    f3_q_r   [DEPTH];
  logic [31:0]   data_q_r [DEPTH];

  logic [PW-1:0] head_r;
  logic [PW-1:0] tail_r;
  logic [CW-1:0] count_r;

  logic          mem_we_r;
  logic [31:0]   mem_addr_r;
  logic [2:0]    mem_funct3_r;
  logic [31:0]   mem_wdata_r;

  logic          full_s;
  logic          push_s;
  logic          pop_s;

  // st_ready depends only on occupancy, so a pop in the same cycle does not
  // open a slot for the ROB. Invalid store codes are consumed but not written.
  assign full_s = (count_r == FULL_CNT);
  assign push_s = st_valid && !full_s && (st_size_f(st_funct3) != 3'd0);
  assign pop_s  = (count_r != {CW{1'b0}}) && drain_en;

  // Write the accepted store into the tail slot.
  always_ff @(posedge clk) begin
    if (push_s) begin
      addr_q_r[tail_r] <= st_addr;
      f3_q_r[tail_r]   <= st_funct3;
      data_q_r[tail_r] <= st_data;
    end
  end

  // Head/tail pointers and the occupancy counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_r  <= {PW{1'b0}};
      tail_r  <= {PW{1'b0}};
      count_r <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        tail_r <= tail_r + PTR_ONE;
      end
      if (pop_s) begin
        head_r <= head_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Registered write stage. The address, width and data hold their values
  // while idle, and only the strobe drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_we_r     <= 1'b0;
      mem_addr_r   <= 32'd0;
      mem_funct3_r <= 3'd0;
      mem_wdata_r  <= 32'd0;
    end else if (pop_s) begin
      mem_we_r     <= 1'b1;
      mem_addr_r   <= addr_q_r[head_r];
      mem_funct3_r <= f3_q_r[head_r];
      mem_wdata_r  <= data_q_r[head_r];
    end else begin
      mem_we_r     <= 1'b0;
    end
  end

  assign st_ready   = !full_s;
  assign mem_we     = mem_we_r;
  assign mem_addr   = mem_addr_r;
  assign mem_funct3 = mem_funct3_r;
  assign mem_wdata  = mem_wdata_r;
  assign count      = count_r;
  assign empty      = (count_r == {CW{1'b0}}) && !mem_we_r;

  logic [2:0]    ld_size_s;
  logic          sel_found_s;
  logic          take_s;
  logic [PW-1:0] idx_s;
`ifdef STBUF_FWD_EN
  logic          sel_cover_s;
  logic [1:0]    sel_off_s;
  logic [31:0]   sel_data_s;
`endif

  // Youngest-overlap search. The in-flight stage is the oldest candidate,
  // then queue slots from head toward tail. Each later match replaces the
  // earlier one, so the youngest overlapping store is what remains.
  always_comb begin
    ld_size_s   = ld_size_f(ld_funct3);
    sel_found_s = 1'b0;
    idx_s       = head_r;
    take_s      = 1'b0;
`ifdef STBUF_FWD_EN
    sel_cover_s = 1'b0;
    sel_off_s   = 2'd0;
    sel_data_s  = 32'd0;
`endif
    take_s      = mem_we_r &&
                  overlap_f(mem_addr_r, st_size_f(mem_funct3_r), ld_addr, ld_size_s);
    sel_found_s = sel_found_s || take_s;
`ifdef STBUF_FWD_EN
    sel_cover_s = take_s ? covers_f(mem_addr_r, st_size_f(mem_funct3_r), ld_addr, ld_size_s)
                         : sel_cover_s;
    sel_off_s   = take_s ? (ld_addr[1:0] - mem_addr_r[1:0]) : sel_off_s;
    sel_data_s  = take_s ? mem_wdata_r : sel_data_s;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      idx_s       = head_r + PW'(k);
      take_s      = (CW'(k) < count_r) &&
                    overlap_f(addr_q_r[idx_s], st_size_f(f3_q_r[idx_s]), ld_addr, ld_size_s);
      sel_found_s = sel_found_s || take_s;
`ifdef STBUF_FWD_EN
      sel_cover_s = take_s ? covers_f(addr_q_r[idx_s], st_size_f(f3_q_r[idx_s]), ld_addr, ld_size_s)
                           : sel_cover_s;
      sel_off_s   = take_s ? (ld_addr[1:0] - addr_q_r[idx_s][1:0]) : sel_off_s;
      sel_data_s  = take_s ? data_q_r[idx_s] : sel_data_s;
`endif
    end
  end

`ifdef STBUF_FWD_EN
  logic [31:0] shifted_s;

  // Pick the loaded bytes from the selected store and extend them. A covered
  // load always starts within 0..3 bytes of the store address, so the low two
  // address bits are enough to get the offset.
  always_comb begin
    ld_fwd_hit  = 1'b0;
    ld_fwd_data = 32'd0;
    ld_conflict = 1'b0;
    shifted_s   = sel_data_s >> {sel_off_s, 3'b000};
    if (ld_valid && (ld_size_s != 3'd0) && sel_found_s) begin
      if (sel_cover_s) begin
        ld_fwd_hit = 1'b1;
        case (ld_funct3)
          3'b000:  ld_fwd_data = {{24{shifted_s[7]}}, shifted_s[7:0]};
          3'b001:  ld_fwd_data = {{16{shifted_s[15]}}, shifted_s[15:0]};
          3'b010:  ld_fwd_data = shifted_s;
          3'b100:  ld_fwd_data = {24'd0, shifted_s[7:0]};
          3'b101:  ld_fwd_data = {16'd0, shifted_s[15:0]};
          default: ld_fwd_data = 32'd0;
        endcase
      end else begin
        ld_conflict = 1'b1;
      end
    end else begin
      ld_conflict = 1'b0;
    end
  end
`else
  // No forwarding: a load that overlaps any buffered or in-flight store stalls.
  always_comb begin
    ld_fwd_hit  = 1'b0;
    ld_fwd_data = 32'd0;
    ld_conflict = 1'b0;
    if (ld_valid && (ld_size_s != 3'd0) && sel_found_s) begin
      ld_conflict = 1'b1;
    end else begin
      ld_conflict = 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_store_commit_buffer.sv
module tb_store_commit_buffer;

  localparam int DEPTH = 4;
`ifdef STBUF_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [2:0]  st_funct3;
  logic [31:0] st_data;
  logic        drain_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_wdata;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic [2:0]  ld_funct3;
  logic        ld_fwd_hit;
  logic [31:0] ld_fwd_data;
  logic        ld_conflict;
  logic [2:0]  count;
  logic        empty;

  always #5 clk = ~clk;

  store_commit_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
    .st_funct3(st_funct3), .st_data(st_data), .drain_en(drain_en),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_funct3(mem_funct3), .mem_wdata(mem_wdata),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_funct3(ld_funct3),
    .ld_fwd_hit(ld_fwd_hit), .ld_fwd_data(ld_fwd_data), .ld_conflict(ld_conflict),
    .count(count), .empty(empty)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: program-ordered queue of stores plus the write stage.
  typedef struct packed { logic [31:0] addr; logic [2:0] f3; logic [31:0] data; } st_t;
  st_t         q[$];
  logic        m_we   = 1'b0;
  logic [31:0] m_addr = 32'd0;
  logic [2:0]  m_f3   = 3'd0;
  logic [31:0] m_data = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic int st_bytes(input logic [2:0] f);
    case (f)
      3'b000:  return 1;
      3'b001:  return 2;
      3'b010:  return 4;
      default: return 0;
    endcase
  endfunction

  function automatic int ld_bytes(input logic [2:0] f);
    case (f)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  // Byte-level lookup: scan stores youngest first. The first store sharing
  // any byte with the load decides the result.
  function automatic void model_lookup(input logic lv, input logic [31:0] la, input logic [2:0] lf,
                                       output logic hit, output logic [31:0] data, output logic conf);
    st_t    lst[$];
    st_t    s;
    int     lsize;
    int     ssize;
    longint b;
    longint sa;
    bit     ov;
    bit     cv;
    logic [31:0] val;
    logic [31:0] sh;
    hit = 1'b0; data = 32'd0; conf = 1'b0;
    lsize = ld_bytes(lf);
    if (!lv || lsize == 0) return;
    if (m_we) lst.push_back('{addr: m_addr, f3: m_f3, data: m_data});
    foreach (q[i]) lst.push_back(q[i]);
    for (int i = lst.size() - 1; i >= 0; i--) begin
      s = lst[i];
      ssize = st_bytes(s.f3);
      sa = longint'(s.addr);
      ov = 1'b0; cv = 1'b1;
      for (int j = 0; j < lsize; j++) begin
        b = longint'(la) + j;
        if (b >= sa && b < sa + ssize) ov = 1'b1;
        else cv = 1'b0;
      end
      if (ov) begin
        if (FWD && cv) begin
          hit = 1'b1;
          val = 32'd0;
          for (int j = 0; j < lsize; j++) begin
            b = longint'(la) + j;
            sh = s.data >> (8 * int'(b - sa));
            val[8*j +: 8] = sh[7:0];
          end
          case (lf)
            3'b000:  data = {{24{val[7]}}, val[7:0]};
            3'b001:  data = {{16{val[15]}}, val[15:0]};
            default: data = val;
          endcase
        end else begin
          conf = 1'b1;
        end
        return;
      end
    end
  endfunction

  // Advance the model with the inputs the DUT sees at this edge, then step.
  task automatic tick();
    bit push;
    bit pop;
    if (reset) begin
      q.delete();
      m_we = 1'b0; m_addr = 32'd0; m_f3 = 3'd0; m_data = 32'd0;
    end else begin
      push = st_valid && (q.size() < DEPTH) && (st_bytes(st_funct3) != 0);
      pop  = (q.size() > 0) && drain_en;
      if (pop) begin
        m_we = 1'b1; m_addr = q[0].addr; m_f3 = q[0].f3; m_data = q[0].data;
        void'(q.pop_front());
      end else begin
        m_we = 1'b0;
      end
      if (push) q.push_back('{addr: st_addr, f3: st_funct3, data: st_data});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag);
    logic        eh;
    logic [31:0] ed;
    logic        ec;
    model_lookup(ld_valid, ld_addr, ld_funct3, eh, ed, ec);
    check({tag, "_ready"}, 32'(st_ready), 32'(q.size() < DEPTH));
    check({tag, "_count"}, 32'(count), 32'(q.size()));
    check({tag, "_empty"}, 32'(empty), 32'((q.size() == 0) && !m_we));
    check({tag, "_we"}, 32'(mem_we), 32'(m_we));
    check({tag, "_addr"}, mem_addr, m_addr);
    check({tag, "_f3"}, 32'(mem_funct3), 32'(m_f3));
    check({tag, "_wdata"}, mem_wdata, m_data);
    check({tag, "_hit"}, 32'(ld_fwd_hit), 32'(eh));
    check({tag, "_fdata"}, ld_fwd_data, ed);
    check({tag, "_conf"}, 32'(ld_conflict), 32'(ec));
  endtask

  task automatic put_store(input logic [31:0] a, input logic [2:0] f, input logic [31:0] d);
    st_valid = 1'b1; st_addr = a; st_funct3 = f; st_data = d;
  endtask

  typedef struct packed {
    logic lv; logic [31:0] la; logic [2:0] lf; logic eh; logic [31:0] ed; logic ec;
  } vec_t;
  vec_t vt [16];

  logic [31:0] got_addr[$];
  int          got_cyc[$];
  logic [31:0] exp_order [5];
  logic [31:0] base;
  int          r;
  bit          acc;

  initial begin
    reset = 1'b1; st_valid = 1'b0; st_addr = 32'd0; st_funct3 = 3'd0; st_data = 32'd0;
    drain_en = 1'b0; ld_valid = 1'b0; ld_addr = 32'd0; ld_funct3 = 3'd0;

    // Lookup vectors against SW 0x200/0x80818283, SW 0x300/0x11111111, SB 0x300/0xAA.
    vt[0]  = '{1'b1, 32'h201, 3'b000, 1'b1, 32'hFFFFFF82, 1'b0};
    vt[1]  = '{1'b1, 32'h203, 3'b100, 1'b1, 32'h00000080, 1'b0};
    vt[2]  = '{1'b1, 32'h200, 3'b010, 1'b1, 32'h80818283, 1'b0};
    vt[3]  = '{1'b1, 32'h204, 3'b010, 1'b0, 32'h0, 1'b0};
    vt[4]  = '{1'b1, 32'h202, 3'b001, 1'b1, 32'hFFFF8081, 1'b0};
    vt[5]  = '{1'b1, 32'h201, 3'b101, 1'b1, 32'h00008182, 1'b0};
    vt[6]  = '{1'b1, 32'h1FE, 3'b010, 1'b0, 32'h0, 1'b1};
    vt[7]  = '{1'b1, 32'h1FF, 3'b000, 1'b0, 32'h0, 1'b0};
    vt[8]  = '{1'b1, 32'h201, 3'b010, 1'b0, 32'h0, 1'b1};
    vt[9]  = '{1'b1, 32'h200, 3'b011, 1'b0, 32'h0, 1'b0};
    vt[10] = '{1'b0, 32'h200, 3'b010, 1'b0, 32'h0, 1'b0};
    vt[11] = '{1'b1, 32'h300, 3'b010, 1'b0, 32'h0, 1'b1};
    vt[12] = '{1'b1, 32'h300, 3'b000, 1'b1, 32'hFFFFFFAA, 1'b0};
    vt[13] = '{1'b1, 32'h301, 3'b100, 1'b1, 32'h00000011, 1'b0};
    vt[14] = '{1'b1, 32'h300, 3'b001, 1'b0, 32'h0, 1'b1};
    vt[15] = '{1'b1, 32'h400, 3'b010, 1'b0, 32'h0, 1'b0};

    // Reset values
    tick(); tick();
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_ready", 32'(st_ready), 32'd1);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_f3", 32'(mem_funct3), 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    reset = 1'b0;

    // Single store drain: mem_we only in the second cycle after acceptance
    drain_en = 1'b1;
    put_store(32'h100, 3'b010, 32'hDEADBEEF);
    tick();
    st_valid = 1'b0;
    check("single_we_n1", 32'(mem_we), 32'd0);
    check("single_cnt_n1", 32'(count), 32'd1);
    tick();
    check("single_we_n2", 32'(mem_we), 32'd1);
    check("single_addr", mem_addr, 32'h100);
    check("single_f3", 32'(mem_funct3), 32'd2);
    check("single_wdata", mem_wdata, 32'hDEADBEEF);
    check("single_empty_n2", 32'(empty), 32'd0);
    tick();
    check("single_we_n3", 32'(mem_we), 32'd0);
    check("single_empty_n3", 32'(empty), 32'd1);
    check("single_addr_hold", mem_addr, 32'h100);

    // Fill to full, hold a fifth store, then drain in order
    drain_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      put_store(32'(4 * i), 3'b010, 32'hA0 + 32'(i));
      #1 check("fill_ready", 32'(st_ready), 32'd1);
      tick();
    end
    put_store(32'h10, 3'b010, 32'hA4);
    #1 check("full_count", 32'(count), 32'd4);
    check("full_ready", 32'(st_ready), 32'd0);
    tick();
    check("held_count", 32'(count), 32'd4);
    check("held_we", 32'(mem_we), 32'd0);
    drain_en = 1'b1;
    #1 check("full_pop_ready", 32'(st_ready), 32'd0);
    for (int c = 0; c < 10; c++) begin
      acc = st_valid && st_ready;
      tick();
      if (acc) st_valid = 1'b0;
      if (mem_we) begin
        got_addr.push_back(mem_addr);
        got_cyc.push_back(c);
      end
    end
    exp_order[0] = 32'h0; exp_order[1] = 32'h4; exp_order[2] = 32'h8;
    exp_order[3] = 32'hC; exp_order[4] = 32'h10;
    check("order_pulses", 32'(got_addr.size()), 32'd5);
    for (int k = 0; k < 5 && k < got_addr.size(); k++)
      check($sformatf("order_addr%0d", k), got_addr[k], exp_order[k]);
    if (got_cyc.size() == 5) check("order_back_to_back", 32'(got_cyc[4] - got_cyc[0]), 32'd4);
    else check("order_back_to_back", 32'(got_cyc.size()), 32'd5);

    // Forwarding table
    drain_en = 1'b0;
    put_store(32'h200, 3'b010, 32'h80818283); tick();
    put_store(32'h300, 3'b010, 32'h11111111); tick();
    put_store(32'h300, 3'b000, 32'h123456AA); tick();
    put_store(32'h400, 3'b011, 32'h55555555); tick();
    st_valid = 1'b0;
    check("tbl_count", 32'(count), 32'd3);
    for (int i = 0; i < 16; i++) begin
      ld_valid = vt[i].lv; ld_addr = vt[i].la; ld_funct3 = vt[i].lf;
      #1;
      check($sformatf("vec%0d_hit", i), 32'(ld_fwd_hit), FWD ? 32'(vt[i].eh) : 32'd0);
      check($sformatf("vec%0d_data", i), ld_fwd_data, FWD ? vt[i].ed : 32'd0);
      check($sformatf("vec%0d_conf", i), 32'(ld_conflict),
            FWD ? 32'(vt[i].ec) : 32'(vt[i].eh | vt[i].ec));
    end
    ld_valid = 1'b0;
    drain_en = 1'b1;
    for (int n = 0; n < 20 && !empty; n++) tick();
    check("drain_done", 32'(empty), 32'd1);

    // In-flight stage is visible to lookups during its mem_we cycle
    put_store(32'h40, 3'b001, 32'h00001234);
    tick();
    st_valid = 1'b0;
    tick();
    ld_valid = 1'b1; ld_addr = 32'h40; ld_funct3 = 3'b101;
    #1;
    check("inflight_we", 32'(mem_we), 32'd1);
    check("inflight_count", 32'(count), 32'd0);
    check("inflight_hit", 32'(ld_fwd_hit), 32'(FWD));
    check("inflight_data", ld_fwd_data, FWD ? 32'h00001234 : 32'd0);
    check("inflight_conf", 32'(ld_conflict), 32'(!FWD));
    tick();
    check("retired_hit", 32'(ld_fwd_hit), 32'd0);
    check("retired_conf", 32'(ld_conflict), 32'd0);
    ld_valid = 1'b0;

    // Reset mid-drain
    drain_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      put_store(32'h500 + 32'(4 * i), 3'b010, 32'hC0 + 32'(i));
      tick();
    end
    st_valid = 1'b0;
    drain_en = 1'b1;
    tick();
    check("mid_we_before", 32'(mem_we), 32'd1);
    check("mid_count_before", 32'(count), 32'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_we_after", 32'(mem_we), 32'd0);
    check("mid_count_after", 32'(count), 32'd0);
    check("mid_empty_after", 32'(empty), 32'd1);
    check("mid_addr_after", mem_addr, 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("mid_no_write%0d", i), 32'(mem_we), 32'd0);
    end

    // Randomised traffic against the model
    for (int it = 0; it < 600; it++) begin
      base = ($urandom_range(0, 9) == 0) ? 32'hFFFFFFF8 : 32'h00001000;
      reset = ($urandom_range(0, 99) == 0);
      st_valid = 1'($urandom_range(0, 1));
      st_addr = base + 32'($urandom_range(0, 7));
      r = int'($urandom_range(0, 9));
      st_funct3 = (r < 3) ? 3'b000 : (r < 6) ? 3'b001 : (r < 9) ? 3'b010 : 3'($urandom_range(3, 7));
      st_data = $urandom;
      drain_en = 1'($urandom_range(0, 1));
      ld_valid = ($urandom_range(0, 4) != 0);
      ld_addr = base + 32'($urandom_range(0, 7));
      ld_funct3 = 3'($urandom_range(0, 7));
      #1;
      check_all("rnd");
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
